// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU types: register address, data word, writeback source select.
package mips_cpu_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_e;

endpackage

// File: rtl/mips_cpu_reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, a new mark wins over a clear in the same cycle.
module mips_cpu_reg_scoreboard
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        set_valid,
  input  logic [4:0]  set_addr,
  input  logic        clr_valid,
  input  logic [4:0]  clr_addr,
  output logic [31:0] pending
);

  word_t set_vec;
  word_t clr_vec;
  word_t pending_next;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_valid && (set_addr != REG_ZERO)) set_vec = 32'h1 << set_addr;
    if (clr_valid) clr_vec = 32'h1 << clr_addr;
    pending_next    = (pending & ~clr_vec) | set_vec;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (clk_enable) begin
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/mips_cpu_regfile_write_arbiter.sv
// Register-file write port arbiter: MEM has priority, a starvation counter forces ALU through.
module mips_cpu_regfile_write_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mark_valid,
  input  logic [4:0]  mark_addr,
  output logic [4:0]  write_addr_c,
  output logic        write_enable_c,
  output logic [31:0] write_data_c,
  output logic [31:0] reg_pending,
  output logic        starve_flag
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  wb_src_e          src;
  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    src         = WB_NONE;
    starve_flag = 1'b0;
    if (clk_enable && !reset) begin
      if (alu_valid && (starve_cnt >= LIMIT)) begin
        src         = WB_ALU;
        starve_flag = 1'b1;
      end else if (mem_valid) begin
        src = WB_MEM;
      end else if (alu_valid) begin
        src = WB_ALU;
      end
    end
  end

  always_comb begin
    alu_ready    = (src == WB_ALU);
    mem_ready    = (src == WB_MEM);
    write_addr_c = '0;
    write_data_c = '0;
    case (src)
      WB_ALU: begin
        write_addr_c = alu_addr;
        write_data_c = alu_data;
      end
      WB_MEM: begin
        write_addr_c = mem_addr;
        write_data_c = mem_data;
      end
      default: ;
    endcase
    // $zero writes are still consumed; only the enable is suppressed
    write_enable_c = (src != WB_NONE) && (write_addr_c != REG_ZERO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (clk_enable) begin
      if (alu_valid && !alu_ready) begin
        if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  mips_cpu_reg_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .set_valid  (mark_valid),
    .set_addr   (mark_addr),
    .clr_valid  (src != WB_NONE),
    .clr_addr   (write_addr_c),
    .pending    (reg_pending)
  );

endmodule

// File: tb/tb_mips_cpu_regfile_write_arbiter.sv
// Directed bench for the register-file write arbiter with hand-computed expectations.
module tb_mips_cpu_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mark_valid;
  logic [4:0]  mark_addr;
  logic [4:0]  write_addr_c;
  logic        write_enable_c;
  logic [31:0] write_data_c;
  logic [31:0] reg_pending;
  logic        starve_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_cpu_regfile_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_addr       (alu_addr),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mark_valid     (mark_valid),
    .mark_addr      (mark_addr),
    .write_addr_c   (write_addr_c),
    .write_enable_c (write_enable_c),
    .write_data_c   (write_data_c),
    .reg_pending    (reg_pending),
    .starve_flag    (starve_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs may change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem_win(input string tag);
    chk(tag, mem_ready, 1'b1);
    chk(tag, alu_ready, 1'b0);
    chk(tag, starve_flag, 1'b0);
    chk(tag, write_addr_c, 5'd6);
  endtask

  task automatic chk_alu_forced(input string tag);
    chk(tag, alu_ready, 1'b1);
    chk(tag, mem_ready, 1'b0);
    chk(tag, starve_flag, 1'b1);
    chk(tag, write_addr_c, 5'd5);
    chk(tag, write_data_c, 32'hA1A1_0005);
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b1;
    alu_valid  = 1'b1;
    alu_addr   = 5'd5;
    alu_data   = 32'hA1A1_0005;
    mem_valid  = 1'b1;
    mem_addr   = 5'd6;
    mem_data   = 32'hB2B2_0006;
    mark_valid = 1'b0;
    mark_addr  = 5'd0;

    // Reset with requests pending: nothing granted
    #1;
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_we", write_enable_c, 1'b0);
    tick();
    tick();
    reset     = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("idle_pending", reg_pending, 32'h0);
    chk("idle_we", write_enable_c, 1'b0);
    chk("idle_alu_ready", alu_ready, 1'b0);
    chk("idle_mem_ready", mem_ready, 1'b0);
    chk("idle_waddr", write_addr_c, 5'd0);
    chk("idle_wdata", write_data_c, 32'h0);

    // Contention: MEM wins 4 cycles, ALU forced on the 5th, MEM again on the 6th
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    #1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk_mem_win("cont_mem");
      chk("cont_mem_wdata", write_data_c, 32'hB2B2_0006);
      tick();
    end
    chk_alu_forced("cont_alu_forced");
    chk("cont_alu_we", write_enable_c, 1'b1);
    tick();
    chk_mem_win("cont_mem_after");
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();

    // Scoreboard mark then clear by ALU write
    mark_valid = 1'b1;
    mark_addr  = 5'd9;
    tick();
    mark_valid = 1'b0;
    #1;
    chk("sb_mark9", reg_pending, 32'h0000_0200);
    alu_valid = 1'b1;
    alu_addr  = 5'd9;
    alu_data  = 32'hDEAD_BEEF;
    #1;
    chk("sb_alu_ready", alu_ready, 1'b1);
    chk("sb_we", write_enable_c, 1'b1);
    chk("sb_waddr", write_addr_c, 5'd9);
    chk("sb_wdata", write_data_c, 32'hDEAD_BEEF);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("sb_cleared", reg_pending, 32'h0);

    // Mark and write the same register in one cycle: set wins
    mark_valid = 1'b1;
    mark_addr  = 5'd9;
    tick();
    alu_valid = 1'b1;
    tick();
    mark_valid = 1'b0;
    alu_valid  = 1'b0;
    #1;
    chk("sb_set_wins", reg_pending, 32'h0000_0200);
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    #1;
    chk("sb_unmarked_clear", reg_pending, 32'h0);

    // $zero handling
    mem_valid = 1'b1;
    mem_addr  = 5'd0;
    mem_data  = 32'h1234_5678;
    #1;
    chk("zero_mem_ready", mem_ready, 1'b1);
    chk("zero_we", write_enable_c, 1'b0);
    tick();
    mem_valid  = 1'b0;
    mem_addr   = 5'd6;
    mem_data   = 32'hB2B2_0006;
    mark_valid = 1'b1;
    mark_addr  = 5'd0;
    tick();
    mark_valid = 1'b0;
    #1;
    chk("zero_mark", reg_pending, 32'h0);

    // Stall: build count 2, freeze 3 cycles, resume from the frozen count
    alu_addr   = 5'd5;
    alu_data   = 32'hA1A1_0005;
    mark_valid = 1'b1;
    mark_addr  = 5'd12;
    tick();
    mark_valid = 1'b0;
    alu_valid  = 1'b1;
    mem_valid  = 1'b1;
    tick();
    tick();
    clk_enable = 1'b0;
    mark_valid = 1'b1;
    mark_addr  = 5'd13;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk("stall_alu_ready", alu_ready, 1'b0);
      chk("stall_mem_ready", mem_ready, 1'b0);
      chk("stall_we", write_enable_c, 1'b0);
      tick();
    end
    mark_valid = 1'b0;
    #1;
    chk("stall_pending", reg_pending, 32'h0000_1000);
    clk_enable = 1'b1;
    #1;
    chk_mem_win("resume_mem1");
    tick();
    chk_mem_win("resume_mem2");
    tick();
    chk_alu_forced("resume_alu_forced");
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();

    // Reset mid-contention with count 3
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_alu_ready", alu_ready, 1'b0);
    chk("midrst_mem_ready", mem_ready, 1'b0);
    chk("midrst_we", write_enable_c, 1'b0);
    chk("midrst_starve", starve_flag, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_pending", reg_pending, 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk_mem_win("postrst_mem");
      tick();
    end
    chk_alu_forced("postrst_alu_forced");
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_regfile_write_arbiter.md
Name: mips_cpu_regfile_write_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: the ALU path (ALU) and the load/multi-cycle path (MEM). Drives the register file's write-port signals directly. Keeps a 32-entry pending-write scoreboard that the decode/hazard logic queries, so reads of not-yet-written registers can be stalled. Fixed priority favours MEM, with a starvation counter that guarantees ALU progress.

Parameters:
STARVE_LIMIT, 4, consecutive cycles ALU may be refused while valid before it is forced to win (range 1..15)
CNT_W, 4, width of starvation counter; must hold STARVE_LIMIT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
clk_enable  input  1  global stall; low freezes all state and grants nothing
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle
alu_addr  input  5  ALU destination register
alu_data  input  32  ALU writeback data
mem_valid  input  1  MEM writeback request
mem_ready  output  1  MEM request accepted this cycle
mem_addr  input  5  MEM destination register
mem_data  input  32  MEM writeback data
mark_valid  input  1  issue stage reserves a destination register
mark_addr  input  5  register to mark pending
write_addr_c  output  5  register-file write address
write_enable_c  output  1  register-file write enable
write_data_c  output  32  register-file write data
reg_pending  output  32  bit i = 1: register i has an outstanding write
starve_flag  output  1  ALU forced-grant active this cycle (debug)

Behaviour:
- Handshake: a request transfers on a cycle where valid && ready && clk_enable. Ready is combinational from the valid signals and the counter; there is no ready→valid dependency. Requesters hold addr/data stable while valid && !ready.
- Grant is combinational, evaluated in this order:
  - clk_enable=0 or reset=1: both readys 0, write_enable_c 0.
  - ALU valid and starve_cnt ≥ STARVE_LIMIT: grant ALU; starve_flag=1.
  - Otherwise MEM valid: grant MEM.
  - Otherwise ALU valid: grant ALU.
  - Exactly one ready is high at most.
- Write port: on a grant, write_addr_c/write_data_c = granted addr/data. write_enable_c = 1 only if the granted addr ≠ 0. A write to $zero is consumed (ready=1) but not written. With no grant, write_enable_c=0 and write_addr_c/write_data_c=0.
- Latency: the register file captures the data at the same rising edge as the handshake, so data is readable the next cycle.
- Starvation counter starve_cnt (CNT_W bits, registered), updated only when clk_enable=1:
  - ALU valid && !alu_ready: increment, saturating at STARVE_LIMIT.
  - ALU granted, or ALU not valid: cleared to 0.
- Scoreboard reg_pending (registered), updated only when clk_enable=1:
  - Set: bit mark_addr when mark_valid and mark_addr ≠ 0.
  - Clear: bit of the granted addr on a transfer.
  - Same register set and cleared in the same cycle: set wins (new producer).
  - Bit 0 is always 0.
  - Marking an already-pending register keeps it 1 (no counting).
  - Clearing a register that is not pending is harmless.
- Reset (synchronous): reg_pending=0, starve_cnt=0. All outputs are 0 while reset is high. Reset mid-handshake drops the request: no write occurs, and the requester must re-present it.
- The block does not require a mark before a write; an unmarked write is legal.

Decomposition:
- Shared package mips_cpu_pkg:
  - typedef reg_addr_t (logic [4:0])
  - typedef word_t (logic [31:0])
  - constant REG_ZERO = 5'd0
  - enum wb_src_e {WB_NONE, WB_ALU, WB_MEM} for the grant select
- One sub-module: mips_cpu_reg_scoreboard (the 32-bit set/clear vector with set-wins priority). Grant logic and the counter stay in the top module.

Test Plan:
- Reset then idle: reg_pending=0, write_enable_c=0, both readys 0 during reset and 0 after with no valids.
- Contention: alu_valid=mem_valid=1 with alu_addr=5, mem_addr=6 held, STARVE_LIMIT=4 → MEM granted (mem_ready=1) cycles 1-4. Cycle 5: alu_ready=1, starve_flag=1, write_addr_c=5. Next cycle MEM wins again.
- Scoreboard: mark 9 → reg_pending[9]=1. ALU write 9 with data 0xDEADBEEF → write_enable_c=1 that cycle, reg_pending[9]=0 next cycle. Mark 9 and grant write 9 in the same cycle → reg_pending[9] stays 1.
- $zero: mem_valid with addr 0 → mem_ready=1, write_enable_c=0. mark_addr 0 → reg_pending[0] stays 0.
- Stall: clk_enable=0 for 3 cycles with both valid → no readys, starve_cnt and reg_pending unchanged. Re-enable → arbitration resumes from the frozen count.
- Reset mid-contention: starve_cnt=3, reset for 1 cycle → counter is 0 afterward, and MEM wins the next 4 contended cycles.
